// File: rtl/seqdec_sched.sv
// Round-robin scheduler that lends one external serial sequence detector to
// NREQ requesters: grant, clear detector, shift word LSB first, report hit.
module seqdec_sched #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8,
   parameter int IDW   = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ*WIDTH-1:0]   data,
   output logic [NREQ-1:0]         gnt,
   output logic                    det_rst,
   output logic                    det_in,
   input  logic                    det_out,
   output logic                    busy,
   output logic                    done,
   output logic                    hit,
   output logic [IDW-1:0]          hit_id
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_CLEAR = 3'd1;
   localparam logic [2:0] S_SHIFT = 3'd2;
   localparam logic [2:0] S_DRAIN = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic [2:0]       state_q,  state_d;
   logic [IDW-1:0]   ptr_q,    ptr_d;
   logic [IDW-1:0]   owner_q,  owner_d;
   logic [WIDTH-1:0] sreg_q,   sreg_d;
   logic [CW-1:0]    cnt_q,    cnt_d;
   logic             acc_q,    acc_d;
   logic [NREQ-1:0]  gnt_q,    gnt_d;
   logic             det_in_q, det_in_d;
   logic             done_q,   done_d;
   logic             hit_q,    hit_d;
   logic [IDW-1:0]   hit_id_q, hit_id_d;
   logic             busy_q,   busy_d;

   logic             found;
   logic [IDW-1:0]   sel;
   int               idx;

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      owner_d  = owner_q;
      sreg_d   = sreg_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      gnt_d    = '0;
      det_in_d = 1'b0;
      done_d   = 1'b0;
      hit_d    = hit_q;
      hit_id_d = hit_id_q;
      found    = 1'b0;
      sel      = '0;
      idx      = 0;

      // First requesting index at or after the pointer, wrapping modulo NREQ
      for (int k = 0; k < NREQ; k++) begin
         idx = (int'(ptr_q) + k) % NREQ;
         if (!found && req[idx]) begin
            found = 1'b1;
            sel   = IDW'(idx);
         end
      end

      case (state_q)
         S_IDLE: begin
            if (found) begin
               sreg_d     = data[int'(sel)*WIDTH +: WIDTH];
               owner_d    = sel;
               ptr_d      = IDW'((int'(sel) + 1) % NREQ);
               gnt_d[sel] = 1'b1;
               acc_d      = 1'b0;
               state_d    = S_CLEAR;
            end
         end
         S_CLEAR: begin
            det_in_d = sreg_q[0];
            sreg_d   = sreg_q >> 1;
            cnt_d    = '0;
            state_d  = S_SHIFT;
         end
         S_SHIFT: begin
            // Detector output lags one bit, so the first SHIFT cycle shows the cleared state
            if (cnt_q != '0) begin
               acc_d = acc_q | det_out;
            end
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d = S_DRAIN;
            end else begin
               det_in_d = sreg_q[0];
               sreg_d   = sreg_q >> 1;
               cnt_d    = cnt_q + 1'b1;
            end
         end
         S_DRAIN: begin
            acc_d    = acc_q | det_out;
            hit_d    = acc_q | det_out;
            hit_id_d = owner_q;
            done_d   = 1'b1;
            state_d  = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         ptr_q    <= '0;
         owner_q  <= '0;
         sreg_q   <= '0;
         cnt_q    <= '0;
         acc_q    <= 1'b0;
         gnt_q    <= '0;
         det_in_q <= 1'b0;
         done_q   <= 1'b0;
         hit_q    <= 1'b0;
         hit_id_q <= '0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         owner_q  <= owner_d;
         sreg_q   <= sreg_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         gnt_q    <= gnt_d;
         det_in_q <= det_in_d;
         done_q   <= done_d;
         hit_q    <= hit_d;
         hit_id_q <= hit_id_d;
         busy_q   <= busy_d;
      end
   end

   assign det_rst = rst | (state_q == S_CLEAR);
   assign gnt     = gnt_q;
   assign det_in  = det_in_q;
   assign done    = done_q;
   assign hit     = hit_q;
   assign hit_id  = hit_id_q;
   assign busy    = busy_q;

endmodule

// File: tb/tb_seqdec_sched.sv
// Self-checking bench for seqdec_sched with a behavioural stand-in detector
// and a word-level reference model of grant order and hit results.
module tb_seqdec_sched;

   localparam int NREQ  = 4;
   localparam int WIDTH = 8;
   localparam int IDW   = 2;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [NREQ-1:0]       req;
   logic [NREQ*WIDTH-1:0] data;
   logic [NREQ-1:0]       gnt;
   logic                  det_rst;
   logic                  det_in;
   logic                  det_out;
   logic                  busy;
   logic                  done;
   logic                  hit;
   logic [IDW-1:0]        hit_id;

   logic [WIDTH-1:0] dataWords [NREQ];
   logic             detMode;
   logic [3:0]       hist;
   int               seenBits;

   int vectors     = 0;
   int miscompares = 0;
   int cycle       = 0;
   int lastDone    = 0;
   int doneGap     = 0;
   int ptrModel    = 0;
   logic lastHit   = 1'b0;
   int   lastId    = 0;

   seqdec_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
      .clk(clk), .rst(rst), .req(req), .data(data), .gnt(gnt),
      .det_rst(det_rst), .det_in(det_in), .det_out(det_out),
      .busy(busy), .done(done), .hit(hit), .hit_id(hit_id)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   always_comb begin
      for (int i = 0; i < NREQ; i++) data[i*WIDTH +: WIDTH] = dataWords[i];
   end

   // Stand-in detector: mode 0 fires on "1,1", mode 1 on the serial pattern "1,0,1,1"
   always @(posedge clk) begin
      if (det_rst) begin
         hist     <= '0;
         seenBits <= 0;
      end else begin
         hist <= {hist[2:0], det_in};
         if (seenBits < 15) seenBits <= seenBits + 1;
      end
   end

   always_comb det_out = detMode ? (seenBits >= 4 && hist == 4'b1011)
                                 : (seenBits >= 2 && hist[1:0] == 2'b11);

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   always @(negedge clk) checkOutput("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);

   function automatic int rrPick(input logic [NREQ-1:0] r, input int p);
      for (int k = 0; k < NREQ; k++)
         if (r[(p + k) % NREQ]) return (p + k) % NREQ;
      return -1;
   endfunction

   function automatic logic refHit(input logic [WIDTH-1:0] w, input logic mode);
      for (int p = 0; p < WIDTH; p++) begin
         if (!mode && p >= 1 && w[p-1] && w[p]) return 1'b1;
         if (mode && p >= 3 && w[p-3] && !w[p-2] && w[p-1] && w[p]) return 1'b1;
      end
      return 1'b0;
   endfunction

   // Present a request vector, follow one complete scan and compare every phase
   task automatic applyStimulus(input logic [NREQ-1:0] reqv, output int waited);
      int               expId;
      logic [WIDTH-1:0] word;
      logic [WIDTH-1:0] shifted;
      logic             expHit;
      req     = reqv;
      expId   = rrPick(reqv, ptrModel);
      word    = dataWords[expId];
      expHit  = refHit(word, detMode);
      shifted = '0;
      waited  = 0;
      do begin
         @(negedge clk);
         waited++;
      end while (gnt == '0 && waited < 6);
      checkOutput("gnt", 32'(gnt), 32'(1) << expId);
      if (gnt == '0) return;
      req = req & ~gnt;
      ptrModel = (expId + 1) % NREQ;
      checkOutput("clear_det_rst", 32'(det_rst), 32'd1);
      checkOutput("clear_busy", 32'(busy), 32'd1);
      checkOutput("clear_det_in", 32'(det_in), 32'd0);
      checkOutput("held_hit", 32'(hit), 32'(lastHit));
      checkOutput("held_hit_id", 32'(hit_id), 32'(lastId));
      for (int i = 0; i < WIDTH; i++) begin
         @(negedge clk);
         shifted[i] = det_in;
         checkOutput("shift_rst_done", 32'({det_rst, done, gnt}), 32'd0);
      end
      checkOutput("det_in_seq", 32'(shifted), 32'(word));
      @(negedge clk);
      checkOutput("drain", 32'({det_in, det_rst, done}), 32'd0);
      @(negedge clk);
      checkOutput("done", 32'(done), 32'd1);
      checkOutput("done_busy", 32'(busy), 32'd1);
      checkOutput("hit", 32'(hit), 32'(expHit));
      checkOutput("hit_id", 32'(hit_id), 32'(expId));
      doneGap  = cycle - lastDone;
      lastDone = cycle;
      lastHit  = expHit;
      lastId   = expId;
   endtask

   initial begin
      #300000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int   w;
      int   n;
      logic sawDone;

      rst          = 1'b1;
      req          = 4'b1111;
      detMode      = 1'b0;
      dataWords[0] = 8'h00;
      dataWords[1] = 8'($urandom);
      dataWords[2] = 8'h03;
      dataWords[3] = 8'h80;

      repeat (2) begin
         @(negedge clk);
         checkOutput("rst_outputs", 32'({gnt, done, hit, hit_id, busy}), 32'd0);
         checkOutput("rst_det_rst", 32'(det_rst), 32'd1);
      end
      rst = 1'b0;

      applyStimulus(4'b1111, w);
      checkOutput("first_gnt_latency", 32'(w), 32'd1);
      for (int k = 0; k < 3; k++) begin
         applyStimulus(req, w);
         checkOutput("rr_done_gap", 32'(doneGap), 32'd12);
      end

      applyStimulus(4'b1001, w);
      applyStimulus(req, w);

      applyStimulus(4'b0100, w);

      // Abort a scan in its 4th SHIFT cycle
      req = 4'b0001;
      n   = 0;
      do begin
         @(negedge clk);
         n++;
      end while (gnt == '0 && n < 6);
      checkOutput("abort_gnt", 32'(gnt), 32'd1);
      req = '0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("abort_det_rst", 32'(det_rst), 32'd1);
      checkOutput("abort_outputs", 32'({gnt, done, hit, hit_id, busy}), 32'd0);
      rst      = 1'b0;
      ptrModel = 0;
      lastHit  = 1'b0;
      lastId   = 0;
      sawDone  = 1'b0;
      repeat (14) begin
         @(negedge clk);
         if (done || busy) sawDone = 1'b1;
      end
      checkOutput("abort_no_done", 32'(sawDone), 32'd0);
      applyStimulus(4'b0010, w);

      detMode      = 1'b1;
      dataWords[3] = 8'h0D;
      applyStimulus(4'b1000, w);
      dataWords[3] = 8'h05;
      applyStimulus(4'b1000, w);

      repeat (40) begin
         for (int i = 0; i < NREQ; i++) dataWords[i] = 8'($urandom);
         detMode = 1'($urandom_range(0, 1));
         applyStimulus(4'($urandom_range(1, 15)), w);
      end

      req = '0;
      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
